// File: rtl/noise_voice_if.sv
// Register and tick bus of the noise voice: frame-sequencer enables, NRx4x registers and
// write strobes in, channel status and signed sample out.
interface noise_voice_if #(
    parameter int unsigned OUT_WIDTH = 24
);
    logic                 len_tick;
    logic                 env_tick;
    logic [7:0]           NR41;
    logic [7:0]           NR42;
    logic [7:0]           NR43;
    logic [7:0]           NR44;
    logic                 nr41_wr;
    logic                 nr42_wr;
    logic                 nr44_wr;
    logic                 channel_on;
    logic [OUT_WIDTH-1:0] output_wave;

    modport master (
        output len_tick, env_tick, NR41, NR42, NR43, NR44, nr41_wr, nr42_wr, nr44_wr,
        input  channel_on, output_wave
    );

    modport slave (
        input  len_tick, env_tick, NR41, NR42, NR43, NR44, nr41_wr, nr42_wr, nr44_wr,
        output channel_on, output_wave
    );
endinterface

// File: rtl/noise_voice.sv
// LFSR noise voice with length counter, volume envelope and signed output scaling,
// all stepped by tick enables in the single system_clock domain.
module noise_voice #(
    parameter int unsigned OUT_WIDTH   = 24,
    parameter int unsigned LEN_BITS    = 6,
    parameter int unsigned TIMER_SCALE = 1
) (
    input logic          system_clock,
    input logic          reset,
    noise_voice_if.slave bus
);
    localparam logic [LEN_BITS:0] LenFull = {1'b1, {LEN_BITS{1'b0}}};
    localparam logic [LEN_BITS:0] LenOne  = {{LEN_BITS{1'b0}}, 1'b1};

    logic                 r_enabled;
    logic [LEN_BITS:0]    r_len;
    logic [3:0]           r_vol;
    logic [2:0]           r_env_timer;
    logic                 r_env_active;
    logic [14:0]          r_lfsr;
    logic [23:0]          r_timer;
    logic [OUT_WIDTH-1:0] r_out;

    logic                 w_enabled_nxt;
    logic [LEN_BITS:0]    w_len_nxt;
    logic [3:0]           w_vol_nxt;
    logic [2:0]           w_env_timer_nxt;
    logic                 w_env_active_nxt;
    logic [14:0]          w_lfsr_nxt;
    logic [23:0]          w_timer_nxt;
    logic [OUT_WIDTH-1:0] w_out_nxt;
    logic [OUT_WIDTH-1:0] w_amp;

    logic                 w_trigger;
    logic                 w_dac_on;
    logic                 w_freeze;
    logic [23:0]          w_base;
    logic [23:0]          w_period;
    logic                 w_fb;
    logic [14:0]          w_lfsr_step;

    assign w_trigger = bus.nr44_wr & bus.NR44[7];
    assign w_dac_on  = |bus.NR42[7:3];
    assign w_freeze  = bus.NR43[7:4] >= 4'd14;
    assign w_base    = (bus.NR43[2:0] == 3'd0) ? 24'd8 : {17'd0, bus.NR43[2:0], 4'd0};
    assign w_period  = (w_base << bus.NR43[7:4]) * 24'(TIMER_SCALE);
    assign w_fb      = r_lfsr[0] ^ r_lfsr[1];

    always_comb begin
        w_lfsr_step = {w_fb, r_lfsr[14:1]};
        if (bus.NR43[3]) begin
            w_lfsr_step[6] = w_fb;
        end
    end

    always_comb begin
        w_enabled_nxt    = r_enabled;
        w_len_nxt        = r_len;
        w_vol_nxt        = r_vol;
        w_env_timer_nxt  = r_env_timer;
        w_env_active_nxt = r_env_active;
        w_lfsr_nxt       = r_lfsr;
        w_timer_nxt      = r_timer;

        if (bus.nr41_wr) begin
            w_len_nxt = LenFull - {1'b0, bus.NR41[LEN_BITS-1:0]};
        end

        if (r_enabled && !w_freeze) begin
            if (r_timer <= 24'd1) begin
                w_timer_nxt = w_period;
                w_lfsr_nxt  = w_lfsr_step;
            end else begin
                w_timer_nxt = r_timer - 24'd1;
            end
        end

        if (w_trigger) begin
            // Trigger swallows any same-cycle ticks; a same-cycle length load is kept.
            w_enabled_nxt    = w_dac_on;
            if (w_len_nxt == '0) begin
                w_len_nxt = LenFull;
            end
            w_lfsr_nxt       = 15'h7FFF;
            w_timer_nxt      = w_period;
            w_vol_nxt        = bus.NR42[7:4];
            w_env_timer_nxt  = bus.NR42[2:0];
            w_env_active_nxt = 1'b1;
        end else begin
            if (bus.len_tick && bus.NR44[6] && r_len != '0 && !bus.nr41_wr) begin
                w_len_nxt = r_len - LenOne;
                if (r_len == LenOne) begin
                    w_enabled_nxt = 1'b0;
                end
            end
            if (bus.env_tick && r_env_active && bus.NR42[2:0] != 3'd0) begin
                if (r_env_timer <= 3'd1) begin
                    w_env_timer_nxt = bus.NR42[2:0];
                    if (bus.NR42[3]) begin
                        if (r_vol == 4'hF) w_env_active_nxt = 1'b0;
                        else               w_vol_nxt = r_vol + 4'd1;
                    end else begin
                        if (r_vol == 4'h0) w_env_active_nxt = 1'b0;
                        else               w_vol_nxt = r_vol - 4'd1;
                    end
                end else begin
                    w_env_timer_nxt = r_env_timer - 3'd1;
                end
            end
        end

        if (bus.nr42_wr && !w_dac_on) begin
            w_enabled_nxt = 1'b0;
        end
    end

    assign w_amp     = {{(OUT_WIDTH-4){1'b0}}, w_vol_nxt} << (OUT_WIDTH - 8);
    assign w_out_nxt = !w_enabled_nxt ? '0 : (w_lfsr_nxt[0] ? -w_amp : w_amp);

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            r_enabled    <= 1'b0;
            r_len        <= '0;
            r_vol        <= 4'd0;
            r_env_timer  <= 3'd0;
            r_env_active <= 1'b0;
            r_lfsr       <= 15'h7FFF;
            r_timer      <= 24'd0;
            r_out        <= '0;
        end else begin
            r_enabled    <= w_enabled_nxt;
            r_len        <= w_len_nxt;
            r_vol        <= w_vol_nxt;
            r_env_timer  <= w_env_timer_nxt;
            r_env_active <= w_env_active_nxt;
            r_lfsr       <= w_lfsr_nxt;
            r_timer      <= w_timer_nxt;
            r_out        <= w_out_nxt;
        end
    end

    assign bus.channel_on  = r_enabled;
    assign bus.output_wave = r_out;
endmodule

// File: tb/tb_noise_voice.sv
// Directed bench for noise_voice: behavioural model checked every cycle plus literal
// expectations for LFSR sign changes, length expiry, envelope, DAC gating and reset.
module tb_noise_voice;
    localparam int unsigned OW = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    noise_voice_if #(.OUT_WIDTH(OW)) bus ();

    noise_voice #(
        .OUT_WIDTH  (OW),
        .LEN_BITS   (6),
        .TIMER_SCALE(1)
    ) dut (
        .system_clock(clk),
        .reset       (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Model state as plain integers
    int m_en   = 0;
    int m_len  = 0;
    int m_vol  = 0;
    int m_envt = 0;
    int m_enva = 0;
    int m_lfsr = 32'h7FFF;
    int m_tmr  = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int lfsr_advance(input int v, input bit short_mode);
        int x;
        int n;
        x = (v ^ (v >> 1)) & 1;
        n = (v >> 1) | (x << 14);
        if (short_mode) n = (n & ~(1 << 6)) | (x << 6);
        return n;
    endfunction

    function automatic logic [23:0] model_out();
        int a;
        a = m_vol * 65536;
        if (m_en == 0) return 24'd0;
        return ((m_lfsr & 1) != 0) ? 24'(-a) : 24'(a);
    endfunction

    task automatic model_step();
        int n_en, n_len, n_vol, n_envt, n_enva, n_lfsr, n_tmr;
        int s, r, per, ep;
        bit trig, dac;
        n_en = m_en; n_len = m_len; n_vol = m_vol; n_envt = m_envt;
        n_enva = m_enva; n_lfsr = m_lfsr; n_tmr = m_tmr;
        trig = bus.nr44_wr && bus.NR44[7];
        dac  = bus.NR42[7:3] != 5'd0;
        s    = int'(bus.NR43[7:4]);
        r    = int'(bus.NR43[2:0]);
        per  = ((r == 0) ? 8 : 16 * r) << s;
        ep   = int'(bus.NR42[2:0]);

        if (bus.nr41_wr) n_len = 64 - int'(bus.NR41[5:0]);
        if (m_en != 0 && s < 14) begin
            if (m_tmr <= 1) begin
                n_tmr  = per;
                n_lfsr = lfsr_advance(m_lfsr, bus.NR43[3]);
            end else begin
                n_tmr = m_tmr - 1;
            end
        end
        if (trig) begin
            n_en = dac ? 1 : 0;
            if (n_len == 0) n_len = 64;
            n_lfsr = 32'h7FFF;
            n_tmr  = per;
            n_vol  = int'(bus.NR42[7:4]);
            n_envt = ep;
            n_enva = 1;
        end else begin
            if (bus.len_tick && bus.NR44[6] && m_len != 0 && !bus.nr41_wr) begin
                n_len = m_len - 1;
                if (n_len == 0) n_en = 0;
            end
            if (bus.env_tick && m_enva != 0 && ep != 0) begin
                if (m_envt > 1) begin
                    n_envt = m_envt - 1;
                end else begin
                    n_envt = ep;
                    if (bus.NR42[3]) begin
                        if (m_vol == 15) n_enva = 0; else n_vol = m_vol + 1;
                    end else begin
                        if (m_vol == 0) n_enva = 0; else n_vol = m_vol - 1;
                    end
                end
            end
        end
        if (bus.nr42_wr && !dac) n_en = 0;

        m_en = n_en; m_len = n_len; m_vol = n_vol; m_envt = n_envt;
        m_enva = n_enva; m_lfsr = n_lfsr; m_tmr = n_tmr;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_en = 0; m_len = 0; m_vol = 0; m_envt = 0; m_enva = 0;
            m_lfsr = 32'h7FFF; m_tmr = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_on", 32'(bus.channel_on), 32'(m_en));
            check("model_wave", 32'(bus.output_wave), 32'(model_out()));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic trigger(input logic [7:0] nr42, input logic [7:0] nr43, input logic [7:0] nr44);
        bus.NR42 = nr42;
        bus.NR43 = nr43;
        bus.NR44 = nr44 | 8'h80;
        bus.nr44_wr = 1'b1;
        cyc(1);
        bus.nr44_wr = 1'b0;
    endtask

    task automatic write_nr41(input logic [7:0] v);
        bus.NR41 = v;
        bus.nr41_wr = 1'b1;
        cyc(1);
        bus.nr41_wr = 1'b0;
    endtask

    task automatic pulse_len();
        bus.len_tick = 1'b1;
        cyc(1);
        bus.len_tick = 1'b0;
    endtask

    task automatic pulse_env(input int n);
        for (int i = 0; i < n; i++) begin
            bus.env_tick = 1'b1;
            cyc(1);
            bus.env_tick = 1'b0;
        end
    endtask

    initial begin
        bus.len_tick = 1'b0; bus.env_tick = 1'b0;
        bus.NR41 = 8'h00; bus.NR42 = 8'h00; bus.NR43 = 8'h00; bus.NR44 = 8'h00;
        bus.nr41_wr = 1'b0; bus.nr42_wr = 1'b0; bus.nr44_wr = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("reset_on", 32'(bus.channel_on), 32'd0);
        check("reset_wave", 32'(bus.output_wave), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        cyc(2);

        // 15-bit LFSR: negative for 14 steps, sign flips at step 15 (8 cycles per step)
        trigger(8'hF0, 8'h00, 8'h00);
        check("lfsr_trig_on", 32'(bus.channel_on), 32'd1);
        check("lfsr_trig_wave", 32'(bus.output_wave), 32'hF10000);
        cyc(8);
        check("model_lfsr_step1", 32'(m_lfsr), 32'h3FFF);
        cyc(111);
        check("lfsr_step14_wave", 32'(bus.output_wave), 32'hF10000);
        cyc(1);
        check("lfsr_step15_wave", 32'(bus.output_wave), 32'h0F0000);
        cyc(37);

        // Asynchronous reset mid-period, then retrigger as from power-up
        #3 rst = 1'b1;
        #1;
        check("midreset_on", 32'(bus.channel_on), 32'd0);
        check("midreset_wave", 32'(bus.output_wave), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        trigger(8'hF0, 8'h00, 8'h00);
        check("post_reset_wave", 32'(bus.output_wave), 32'hF10000);
        cyc(20);

        // 7-bit mode: sign flips after step 7, then full 127-step period via the model
        trigger(8'hF0, 8'h08, 8'h00);
        cyc(55);
        check("short_step6_wave", 32'(bus.output_wave), 32'hF10000);
        cyc(1);
        check("short_step7_wave", 32'(bus.output_wave), 32'h0F0000);
        cyc(1100);

        // s = 14 freezes the LFSR
        trigger(8'hF0, 8'hE0, 8'h00);
        cyc(200);
        check("freeze_wave", 32'(bus.output_wave), 32'hF10000);

        // Length enabled: load 3E -> 2 ticks to expiry
        write_nr41(8'h3E);
        trigger(8'hF0, 8'h00, 8'h40);
        pulse_len();
        check("len_tick1_on", 32'(bus.channel_on), 32'd1);
        pulse_len();
        check("len_expire_on", 32'(bus.channel_on), 32'd0);
        check("len_expire_wave", 32'(bus.output_wave), 32'd0);

        // Length disabled: ticks ignored
        write_nr41(8'h3E);
        trigger(8'hF0, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) pulse_len();
        check("len_off_on", 32'(bus.channel_on), 32'd1);

        // Length load, trigger and len_tick in one cycle: tick ignored, load kept
        bus.NR41 = 8'h3E; bus.nr41_wr = 1'b1; bus.len_tick = 1'b1;
        trigger(8'hF0, 8'h00, 8'h40);
        bus.nr41_wr = 1'b0; bus.len_tick = 1'b0;
        pulse_len();
        check("collide_tick1_on", 32'(bus.channel_on), 32'd1);
        pulse_len();
        check("collide_tick2_on", 32'(bus.channel_on), 32'd0);

        // Envelope up from 0, period 3, saturating at 15 (LFSR frozen so sign stays negative)
        trigger(8'h0B, 8'hE0, 8'h00);
        check("env_up_start_on", 32'(bus.channel_on), 32'd1);
        check("env_up_start_wave", 32'(bus.output_wave), 32'd0);
        pulse_env(3);
        check("env_up_vol1", 32'(bus.output_wave), 32'hFF0000);
        pulse_env(57);
        check("env_up_sat", 32'(bus.output_wave), 32'hF10000);

        // Envelope down from 15, period 1
        trigger(8'hF1, 8'hE0, 8'h00);
        pulse_env(7);
        check("env_dn_vol8", 32'(bus.output_wave), 32'hF80000);
        pulse_env(8);
        check("env_dn_zero_wave", 32'(bus.output_wave), 32'd0);
        check("env_dn_zero_on", 32'(bus.channel_on), 32'd1);
        pulse_env(4);

        // DAC off via NR42 write, and trigger with DAC off
        trigger(8'hF0, 8'h00, 8'h00);
        cyc(3);
        bus.NR42 = 8'h00; bus.nr42_wr = 1'b1;
        cyc(1);
        bus.nr42_wr = 1'b0;
        check("dac_off_on", 32'(bus.channel_on), 32'd0);
        check("dac_off_wave", 32'(bus.output_wave), 32'd0);
        trigger(8'h00, 8'h00, 8'h00);
        check("dac_off_trig_on", 32'(bus.channel_on), 32'd0);
        cyc(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
